// File: rtl/sa_feed_mover.sv
// Moves PE_SIZE-lane words from the input BRAM into the systolic-array row FIFOs,
// delaying lane i by i cycles so the array sees a diagonal wavefront.
module sa_feed_mover #(
    parameter int FIFO_DATA_WIDTH = 8,
    parameter int PE_SIZE         = 16,
    parameter int MEM_ADDR_WIDTH  = 10,
    parameter int MEM_DATA_WIDTH  = 128,
    parameter int ROW_CNT_WIDTH   = 10
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_i,
    input  logic [MEM_ADDR_WIDTH-1:0]            base_addr_i,
    input  logic [ROW_CNT_WIDTH-1:0]             num_rows_i,
    input  logic                                 stall_i,
    output logic                                 mem_ce0_o,
    output logic [MEM_ADDR_WIDTH-1:0]            mem_addr0_o,
    input  logic [MEM_DATA_WIDTH-1:0]            mem_q0_i,
    output logic [PE_SIZE-1:0]                   wren_o,
    output logic [PE_SIZE*FIFO_DATA_WIDTH-1:0]   wdata_o,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [1:0]                           dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int DCW = $clog2(PE_SIZE + 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(PE_SIZE);

    // Handshake: start_i is a single-cycle request honoured only in IDLE; there is
    // no write-side backpressure, stall_i only gates new BRAM reads while in READ.
    logic [1:0]               state;
    logic [ROW_CNT_WIDTH-1:0] rem;
    logic [DCW-1:0]           drain_cnt;
    logic                     rd_vld;
    logic [PE_SIZE-1:0]       skew_vld;

    assign dbg_state = state;
    assign busy_o    = (state != S_IDLE);
    assign done_o    = (state == S_DONE);
    assign mem_ce0_o = (state == S_READ) && !stall_i;
    assign wren_o    = skew_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            mem_addr0_o <= '0;
            rem         <= '0;
            drain_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        mem_addr0_o <= base_addr_i;
                        rem         <= num_rows_i;
                        drain_cnt   <= '0;
                        state       <= (num_rows_i == '0) ? S_DONE : S_READ;
                    end
                end
                S_READ: begin
                    if (!stall_i) begin
                        mem_addr0_o <= mem_addr0_o + MEM_ADDR_WIDTH'(1);
                        rem         <= rem - ROW_CNT_WIDTH'(1);
                        if (rem == ROW_CNT_WIDTH'(1)) begin
                            state     <= S_DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    // Covers the BRAM latency plus the full skew of the last lane.
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= S_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // skew_vld[j] marks that stage j of the skew pipeline holds a real word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld   <= 1'b0;
            skew_vld <= '0;
        end else begin
            rd_vld   <= mem_ce0_o;
            skew_vld <= {skew_vld[PE_SIZE-2:0], rd_vld};
        end
    end

    // Lane i keeps only its own byte, in a chain i+1 registers deep.
    for (genvar i = 0; i < PE_SIZE; i++) begin : g_lane
        logic [FIFO_DATA_WIDTH-1:0] sr [0:i];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= i; j++) begin
                    sr[j] <= '0;
                end
            end else begin
                if (rd_vld) begin
                    sr[0] <= mem_q0_i[MEM_DATA_WIDTH-1-i*FIFO_DATA_WIDTH -: FIFO_DATA_WIDTH];
                end
                for (int j = 1; j <= i; j++) begin
                    if (skew_vld[j-1]) begin
                        sr[j] <= sr[j-1];
                    end
                end
            end
        end

        assign wdata_o[FIFO_DATA_WIDTH*(i+1)-1 -: FIFO_DATA_WIDTH] = sr[i];
    end

endmodule
